// File: rtl/pwl_seq_ctrl_pkg.sv
// Shared definitions for the PWL chaotic-oscillator sequencer.
// State words are opaque here; the Euler datapath owns the fixed-point format.
package pwl_seq_ctrl_pkg;

    localparam int WIDTH_DEF     = 16;
    localparam int CNT_WIDTH_DEF = 20;
    localparam int DEC_WIDTH_DEF = 8;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_EMIT = 3'd2;
    localparam logic [2:0] S_RUN  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE = S_IDLE,
        ST_LOAD = S_LOAD,
        ST_EMIT = S_EMIT,
        ST_RUN  = S_RUN,
        ST_DONE = S_DONE
    } seq_state_t;

endpackage

// File: rtl/pwl_step_counter.sv
// Loadable down-counter; last is high while the count is 1, i.e. during the
// final step of a decimation interval.
module pwl_step_counter #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         last
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign last = (cnt == W'(1));

endmodule

// File: rtl/pwl_seq_ctrl.sv
// Sequencer: load the initial condition, step the Euler datapath once per
// cycle, and emit one decimated sample every d steps on a valid/ready port.
module pwl_seq_ctrl
    import pwl_seq_ctrl_pkg::*;
#(
    parameter int Width    = WIDTH_DEF,
    parameter int CntWidth = CNT_WIDTH_DEF,
    parameter int DecWidth = DEC_WIDTH_DEF
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic                abort_i,
    input  logic [CntWidth-1:0] n_samples_i,
    input  logic [DecWidth-1:0] decim_i,
    input  logic [Width-1:0]    x0_i,
    input  logic [Width-1:0]    y0_i,
    input  logic [Width-1:0]    z0_i,
    input  logic [Width-1:0]    xn_i,
    input  logic [Width-1:0]    yn_i,
    input  logic [Width-1:0]    zn_i,
    output logic [Width-1:0]    x_o,
    output logic [Width-1:0]    y_o,
    output logic [Width-1:0]    z_o,
    output logic                valid_o,
    input  logic                ready_i,
    output logic                busy_o,
    output logic                done_o
);

    seq_state_t          state;
    logic [CntWidth-1:0] n_q;
    logic [DecWidth-1:0] d_q;
    logic [CntWidth-1:0] smp_cnt;
    logic [CntWidth-1:0] smp_nxt;
    logic                step_load;
    logic                step_dec;
    logic                step_last;

    // smp_cnt never exceeds n_q-1, so the increment cannot wrap
    assign smp_nxt   = smp_cnt + CntWidth'(1);
    assign step_load = (state == ST_EMIT) && ready_i && !abort_i;
    assign step_dec  = (state == ST_RUN) && !abort_i;

    pwl_step_counter #(.W(DecWidth)) u_step_cnt (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .load     (step_load),
        .load_val (d_q),
        .dec      (step_dec),
        .last     (step_last)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state   <= ST_IDLE;
            x_o     <= '0;
            y_o     <= '0;
            z_o     <= '0;
            valid_o <= 1'b0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
            n_q     <= '0;
            d_q     <= '0;
            smp_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        n_q     <= n_samples_i;
                        d_q     <= (decim_i == '0) ? DecWidth'(1) : decim_i;
                        smp_cnt <= '0;
                        busy_o  <= 1'b1;
                        state   <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (abort_i) begin
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                        state  <= ST_DONE;
                    end else begin
                        x_o <= x0_i;
                        y_o <= y0_i;
                        z_o <= z0_i;
                        if (n_q == '0) begin
                            busy_o <= 1'b0;
                            done_o <= 1'b1;
                            state  <= ST_DONE;
                        end else begin
                            valid_o <= 1'b1;
                            state   <= ST_EMIT;
                        end
                    end
                end
                ST_EMIT: begin
                    // a handshake coinciding with abort still counts
                    if (ready_i) smp_cnt <= smp_nxt;
                    if (abort_i || (ready_i && smp_nxt == n_q)) begin
                        valid_o <= 1'b0;
                        busy_o  <= 1'b0;
                        done_o  <= 1'b1;
                        state   <= ST_DONE;
                    end else if (ready_i) begin
                        valid_o <= 1'b0;
                        state   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (abort_i) begin
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                        state  <= ST_DONE;
                    end else begin
                        x_o <= xn_i;
                        y_o <= yn_i;
                        z_o <= zn_i;
                        if (step_last) begin
                            valid_o <= 1'b1;
                            state   <= ST_EMIT;
                        end
                    end
                end
                ST_DONE: begin
                    done_o <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    valid_o <= 1'b0;
                    busy_o  <= 1'b0;
                    done_o  <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwl_seq_ctrl.sv
// Directed bench for pwl_seq_ctrl with a trivial datapath model (x+1 per step).
module tb_pwl_seq_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i, abort_i, ready_i;
    logic [19:0] n_samples_i;
    logic [7:0]  decim_i;
    logic [15:0] x0_i, y0_i, z0_i, xn_i, yn_i, zn_i, x_o, y_o, z_o;
    logic        valid_o, busy_o, done_o;

    pwl_seq_ctrl dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
        .n_samples_i(n_samples_i), .decim_i(decim_i),
        .x0_i(x0_i), .y0_i(y0_i), .z0_i(z0_i),
        .xn_i(xn_i), .yn_i(yn_i), .zn_i(zn_i),
        .x_o(x_o), .y_o(y_o), .z_o(z_o),
        .valid_o(valid_o), .ready_i(ready_i), .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk_i = ~clk_i;

    assign xn_i = x_o + 16'd1;
    assign yn_i = y_o;
    assign zn_i = z_o;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int t0 = 0;

    logic [15:0] hs_x[$];
    logic [15:0] hs_y[$];
    int          hs_c[$];
    int          done_cnt, done_cyc, valid_seen, stall_cnt, stall_err;
    logic        prev_stall;
    logic [15:0] prev_x, prev_y, prev_z;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(negedge clk_i) begin
        if (valid_o) valid_seen <= valid_seen + 1;
        if (valid_o && ready_i) begin
            hs_x.push_back(x_o);
            hs_y.push_back(y_o);
            hs_c.push_back(cyc);
        end
        if (done_o) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (valid_o && !ready_i) stall_cnt <= stall_cnt + 1;
        if (prev_stall && (!valid_o || x_o != prev_x || y_o != prev_y || z_o != prev_z))
            stall_err <= stall_err + 1;
        prev_stall <= valid_o && !ready_i;
        prev_x <= x_o;
        prev_y <= y_o;
        prev_z <= z_o;
    end

    task automatic clear();
        hs_x.delete();
        hs_y.delete();
        hs_c.delete();
        done_cnt = 0;
        done_cyc = 0;
        valid_seen = 0;
        stall_cnt = 0;
        stall_err = 0;
    endtask

    // called just after a rising edge; start is sampled at the next edge
    task automatic start_run(input int n, input int d);
        n_samples_i = 20'(n);
        decim_i = 8'(d);
        start_i = 1'b1;
        t0 = cyc + 1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
    endtask

    task automatic wait_hs(input int n, input string tag);
        for (int i = 0; i < 300; i++) begin
            @(posedge clk_i); #1;
            if (hs_c.size() >= n) break;
        end
        if (hs_c.size() < n) chk(tag, 32'(hs_c.size()), 32'(n));
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 300; i++) begin
            @(posedge clk_i); #1;
            if (done_cnt != 0) break;
        end
        if (done_cnt == 0) chk(tag, 0, 1);
        repeat (3) @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_ni = 1'b0;
        start_i = 1'b0;
        abort_i = 1'b0;
        ready_i = 1'b1;
        n_samples_i = '0;
        decim_i = '0;
        x0_i = 16'h0000;
        y0_i = 16'hE99A;
        z0_i = 16'h0000;
        prev_stall = 1'b0;
        clear();

        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_x", 32'(x_o), 0);
        chk("rst_valid", 32'(valid_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_done", 32'(done_o), 0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        // reset held 3 cycles in the middle of RUN
        clear();
        start_run(3, 4);
        wait_hs(1, "mr_hs_timeout");
        @(posedge clk_i); #1;
        rst_ni = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("mr_x", 32'(x_o), 0);
        chk("mr_y", 32'(y_o), 0);
        chk("mr_valid", 32'(valid_o), 0);
        chk("mr_busy", 32'(busy_o), 0);
        chk("mr_done", 32'(done_o), 0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        repeat (10) @(posedge clk_i);
        @(negedge clk_i);
        chk("mr_no_done", 32'(done_cnt), 0);
        chk("mr_idle_busy", 32'(busy_o), 0);
        chk("mr_hs_count", 32'(hs_c.size()), 1);
        @(posedge clk_i); #1;

        // basic run: n=3, d=4, ready held high
        clear();
        start_run(3, 4);
        wait_done("run_timeout");
        chk("run_count", 32'(hs_c.size()), 3);
        if (hs_c.size() == 3) begin
            chk("run_x0", 32'(hs_x[0]), 0);
            chk("run_x1", 32'(hs_x[1]), 4);
            chk("run_x2", 32'(hs_x[2]), 8);
            for (int i = 0; i < 3; i++) chk("run_y", 32'(hs_y[i]), 32'hE99A);
            chk("run_first_lat", 32'(hs_c[0]), 32'(t0 + 1));
            chk("run_period1", 32'(hs_c[1] - hs_c[0]), 5);
            chk("run_period2", 32'(hs_c[2] - hs_c[1]), 5);
            chk("run_done_cyc", 32'(done_cyc), 32'(hs_c[2] + 1));
        end
        chk("run_done_cnt", 32'(done_cnt), 1);

        // same run with a 7-cycle stall on sample 1
        clear();
        start_run(3, 4);
        wait_hs(1, "st_hs_timeout");
        for (int i = 0; i < 50 && !valid_o; i++) begin
            @(posedge clk_i); #1;
        end
        ready_i = 1'b0;
        repeat (7) @(posedge clk_i);
        #1;
        ready_i = 1'b1;
        wait_done("st_timeout");
        chk("st_count", 32'(hs_c.size()), 3);
        if (hs_c.size() == 3) begin
            chk("st_x0", 32'(hs_x[0]), 0);
            chk("st_x1", 32'(hs_x[1]), 4);
            chk("st_x2", 32'(hs_x[2]), 8);
            chk("st_period1", 32'(hs_c[1] - hs_c[0]), 12);
            chk("st_period2", 32'(hs_c[2] - hs_c[1]), 5);
        end
        chk("st_stall_cycles", 32'(stall_cnt), 7);
        chk("st_stable", 32'(stall_err), 0);
        chk("st_done_cnt", 32'(done_cnt), 1);

        // n=0: LOAD then DONE, never valid
        clear();
        start_run(0, 4);
        wait_done("n0_timeout");
        chk("n0_valid", 32'(valid_seen), 0);
        chk("n0_done_cyc", 32'(done_cyc), 32'(t0 + 1));
        chk("n0_done_cnt", 32'(done_cnt), 1);

        // d=0 behaves as d=1
        clear();
        start_run(4, 0);
        wait_done("d0_timeout");
        chk("d0_count", 32'(hs_c.size()), 4);
        if (hs_c.size() == 4) begin
            for (int i = 0; i < 4; i++) chk("d0_x", 32'(hs_x[i]), 32'(i));
            for (int i = 1; i < 4; i++) chk("d0_period", 32'(hs_c[i] - hs_c[i-1]), 2);
        end
        chk("d0_done_cnt", 32'(done_cnt), 1);

        // abort in the 2nd RUN cycle after sample 2, with a stray start
        clear();
        start_run(5, 4);
        wait_hs(3, "ab_hs_timeout");
        @(posedge clk_i); #1;
        abort_i = 1'b1;
        start_i = 1'b1;
        @(posedge clk_i); #1;
        abort_i = 1'b0;
        start_i = 1'b0;
        @(negedge clk_i);
        chk("ab_done", 32'(done_o), 1);
        chk("ab_busy", 32'(busy_o), 0);
        chk("ab_valid", 32'(valid_o), 0);
        chk("ab_x_frozen", 32'(x_o), 9);
        repeat (6) @(posedge clk_i);
        @(negedge clk_i);
        chk("ab_x_after", 32'(x_o), 9);
        chk("ab_busy_after", 32'(busy_o), 0);
        chk("ab_done_cnt", 32'(done_cnt), 1);
        chk("ab_hs_count", 32'(hs_c.size()), 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
